// File: rtl/clock_divider_by_2n.sv
// clock_divider_by_2n
// -------------------
// Binary clock divider built from one 4-bit synchronous up-counter. Each
// counter bit is exported as a divided output. The outputs are registered
// data signals in the clk domain. They are not clock-tree clocks.
//
// Parameters:
//   WIDTH  - counter width; fixed at 4 (one bit per output div2..div16)
//
// Ports:
//   clk    in   system clock; all state updates on its rising edge
//   rst    in   synchronous reset, active low
//   en     in   count enable, active high; when low the count holds
//   div2   out  counter bit 0 (clk/2 when en is held high)
//   div4   out  counter bit 1 (clk/4)
//   div8   out  counter bit 2 (clk/8)
//   div16  out  counter bit 3 (clk/16)

module clock_divider_by_2n #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic div2,
  output logic div4,
  output logic div8,
  output logic div16
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt;

  // Counter register: reset has priority over enable, and the count wraps modulo 2^WIDTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= CNT_ZERO;
    end else if (en) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  // Ports are wired straight from the counter flops, so the outputs cannot glitch
  assign div2  = cnt[0];
  assign div4  = cnt[1];
  assign div8  = cnt[2];
  assign div16 = cnt[3];

endmodule

// File: tb/tb_clock_divider_by_2n.sv
// Self-checking testbench for clock_divider_by_2n.
// It uses directed stimulus with hand-computed expected values.
// The bench observes {div16,div8,div4,div2} as a 4-bit value.

`timescale 1ns/1ps

module tb_clock_divider_by_2n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div2;
  logic       div4;
  logic       div8;
  logic       div16;
  logic [3:0] obs;

  int errors = 0;
  int checks = 0;

  clock_divider_by_2n #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .div2  (div2),
    .div4  (div4),
    .div8  (div8),
    .div16 (div16)
  );

  assign obs = {div16, div8, div4, div2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for one rising edge, then let the outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one reset edge with en low, then release the reset.
  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        $display("FAIL reset_hold edge%0d got=%b exp=0000", i, obs);
        errors++;
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        $display("FAIL reset_release_en0 edge%0d got=%b exp=0000", i, obs);
        errors++;
      end
    end
  endtask

  task automatic test_continuous();
    logic [3:0] exp;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = 4'(k);
      checks++;
      if (obs !== exp) begin
        $display("FAIL continuous edge%0d got=%b exp=%b", k, obs, exp);
        errors++;
      end
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    checks++;
    if (obs !== 4'b0101) begin
      $display("FAIL pause_pre got=%b exp=0101", obs);
      errors++;
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0101) begin
        $display("FAIL pause_hold edge%0d got=%b exp=0101", i, obs);
        errors++;
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (obs !== 4'b0110) begin
      $display("FAIL pause_resume got=%b exp=0110", obs);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    repeat (11) tick();
    checks++;
    if (obs !== 4'b1011) begin
      $display("FAIL midreset_pre got=%b exp=1011", obs);
      errors++;
    end
    // Reset and enable are both active on this edge, and reset must win.
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL midreset_asserted got=%b exp=0000", obs);
      errors++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      $display("FAIL midreset_release got=%b exp=0001", obs);
      errors++;
    end
  endtask

  task automatic test_period();
    logic [3:0] prev;
    logic [3:0] exp;
    int         highs [4];
    int         toggles [4];
    do_reset();
    en   = 1'b1;
    prev = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      highs[b]   = 0;
      toggles[b] = 0;
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== prev) begin
        $display("FAIL negedge_change edge%0d got=%b exp=%b", k, obs, prev);
        errors++;
      end
      tick();
      exp = 4'(k % 16);
      checks++;
      if (obs !== exp) begin
        $display("FAIL period_value edge%0d got=%b exp=%b", k, obs, exp);
        errors++;
      end
      for (int b = 0; b < 4; b++) begin
        if (obs[b] === 1'b1) highs[b]++;
        if (obs[b] !== prev[b]) toggles[b]++;
      end
      prev = obs;
    end
    // Over 64 edges each bit should be high half the time.
    // Bit b toggles 64 >> b times.
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (highs[b] != 32) begin
        $display("FAIL duty_bit%0d got=%0d exp=32", b, highs[b]);
        errors++;
      end
      checks++;
      if (toggles[b] != (64 >> b)) begin
        $display("FAIL toggles_bit%0d got=%0d exp=%0d", b, toggles[b], 64 >> b);
        errors++;
      end
    end
  endtask

  task automatic test_async_pulse();
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    // This reset pulse falls between rising edges, so it is never sampled.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++;
    if (obs !== 4'b0111) begin
      $display("FAIL async_pulse got=%b exp=0111", obs);
      errors++;
    end
    tick();
    checks++;
    if (obs !== 4'b1000) begin
      $display("FAIL async_pulse_next got=%b exp=1000", obs);
      errors++;
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    test_reset();
    test_continuous();
    test_pause_resume();
    test_reset_mid();
    test_period();
    test_async_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
